fifo_rd_unpack: RTL and testbench

Read-side adapter for `fifo_sync`. It pops wide words from the FIFO, drives the FIFO's `rd_en`, and absorbs the FIFO's one-cycle read latency. Each word is serialized LSB-first into narrower valid/ready beats for downstream datapath consumers (PE input feeders, DMA narrow ports). A 2-word internal buffer keeps the stream at full rate without combinational dependence on FIFO data.

---
 rtl/fifo_rd_unpack.sv | 127 ++++++++++++
 tb/tb_fifo_rd_unpack.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_unpack.sv
// fifo_rd_unpack: read-side adapter for fifo_sync.
// Pops wide words from the FIFO and absorbs its one-cycle read latency.
// Each word is split LSB-first into OUT_WIDE beats on a valid/ready stream.
// A 2-word buffer sustains full rate without a combinational path from FIFO data.
module fifo_rd_unpack #(
    parameter int DATA_WIDE = 64,
    parameter int OUT_WIDE  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [DATA_WIDE-1:0] fifo_dout,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDE-1:0]  m_data,
    output logic                 m_last
);

    localparam int RATIO = DATA_WIDE / OUT_WIDE;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    // Slice table is padded to a power of two so cnt can index it at full width.
    localparam int SLOTS = 1 << CNT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    generate
        if ((OUT_WIDE <= 0) || (OUT_WIDE > DATA_WIDE) || ((DATA_WIDE % OUT_WIDE) != 0)) begin : g_bad_width
            $error("fifo_rd_unpack: DATA_WIDE must be a non-zero multiple of OUT_WIDE");
        end
    endgenerate

    logic [DATA_WIDE-1:0] mem_q [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 inflight_q, inflight_d;
    logic [1:0]           occ_q, occ_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [DATA_WIDE-1:0] head;
    logic [OUT_WIDE-1:0]  slice [SLOTS];
    logic                 beat;
    logic                 pop;
    logic                 capture;
    logic [2:0]           level;

    assign head = mem_q[rd_ptr_q];

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slice
            if (gi < RATIO) begin : g_used
                assign slice[gi] = head[gi*OUT_WIDE +: OUT_WIDE];
            end else begin : g_pad
                assign slice[gi] = '0;
            end
        end
    endgenerate

    assign m_valid = (occ_q != 2'd0);
    assign m_last  = m_valid & (cnt_q == CNT_LAST);
    assign m_data  = m_valid ? slice[cnt_q] : '0;

    assign beat    = m_valid & m_ready;
    assign pop     = beat & m_last;
    // Returning data is dropped if a flush lands on the cycle it arrives.
    assign capture = inflight_q & ~clr;

    // Words held plus in flight, minus the one leaving this cycle. Including
    // pop lets a RATIO=1 stream issue a read every clock.
    assign level      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = rst_n & ~clr & ~fifo_empty & (level <= 3'd1);

    // Next-state for pointers, occupancy, beat index and in-flight flag; flush wins.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        cnt_d      = cnt_q;
        inflight_d = inflight_q;
        if (clr) begin
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            occ_d      = 2'd0;
            cnt_d      = '0;
            inflight_d = 1'b0;
        end else begin
            inflight_d = fifo_rd_en;
            if (capture) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            occ_d = occ_q + {1'b0, capture} - {1'b0, pop};
            if (pop) begin
                cnt_d = '0;
            end else if (beat) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
        end
    end

    // Word buffer: no reset needed, contents are only visible while occ is non-zero.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_q[wr_ptr_q] <= fifo_dout;
        end
    end

endmodule

// File: tb/tb_fifo_rd_unpack.sv
// Directed bench for fifo_rd_unpack: RATIO=4 instance plus a RATIO=1 instance,
// each fed by a small behavioural fifo_sync model with one-cycle read latency.
module tb_fifo_rd_unpack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic clr;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- RATIO=4 instance ----------------
    logic        a_empty, a_rd_en, a_valid, a_ready, a_last;
    logic [63:0] a_dout = '0;
    logic [15:0] a_data;
    logic [63:0] a_mem [512];
    int          a_wr = 0;
    int          a_rd = 0;

    assign a_empty = (a_wr == a_rd);
    always @(posedge clk) begin
        if (a_rd_en) begin
            a_dout <= a_mem[a_rd];
            a_rd   <= a_rd + 1;
        end
    end

    fifo_rd_unpack #(.DATA_WIDE(64), .OUT_WIDE(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .fifo_empty(a_empty), .fifo_rd_en(a_rd_en), .fifo_dout(a_dout),
        .m_valid(a_valid), .m_ready(a_ready), .m_data(a_data), .m_last(a_last)
    );

    // ---------------- RATIO=1 instance ----------------
    logic        b_empty, b_rd_en, b_valid, b_ready, b_last;
    logic [63:0] b_dout = '0;
    logic [63:0] b_data;
    logic [63:0] b_mem [64];
    int          b_wr = 0;
    int          b_rd = 0;

    assign b_empty = (b_wr == b_rd);
    always @(posedge clk) begin
        if (b_rd_en) begin
            b_dout <= b_mem[b_rd];
            b_rd   <= b_rd + 1;
        end
    end

    fifo_rd_unpack #(.DATA_WIDE(64), .OUT_WIDE(64)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(1'b0),
        .fifo_empty(b_empty), .fifo_rd_en(b_rd_en), .fifo_dout(b_dout),
        .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data), .m_last(b_last)
    );

    // ---------------- monitors (sample on falling edge) ----------------
    logic [15:0] a_bt_data [1024];
    logic        a_bt_last [1024];
    int          a_bt_cyc  [1024];
    int          a_nbt = 0;
    int          a_rd_cyc  [512];
    int          a_nrd = 0;
    int          empty_viol = 0;
    int          stab_viol = 0;
    int          out_cnt = 0;
    int          max_out = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always @(negedge clk) begin
        int nxt;
        if (!rst_n) begin
            out_cnt    <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!a_valid || a_data !== prev_data || a_last !== prev_last))
                stab_viol <= stab_viol + 1;
            if (a_rd_en) begin
                a_rd_cyc[a_nrd] <= cyc;
                a_nrd <= a_nrd + 1;
                if (a_empty) empty_viol <= empty_viol + 1;
            end
            if (a_valid && a_ready) begin
                a_bt_data[a_nbt] <= a_data;
                a_bt_last[a_nbt] <= a_last;
                a_bt_cyc[a_nbt]  <= cyc;
                a_nbt <= a_nbt + 1;
            end
            if (clr) nxt = 0;
            else nxt = out_cnt + (a_rd_en ? 1 : 0) - ((a_valid && a_ready && a_last) ? 1 : 0);
            out_cnt    <= nxt;
            max_out    <= (nxt > max_out) ? nxt : max_out;
            prev_stall <= a_valid && !a_ready && !clr;
            prev_data  <= a_data;
            prev_last  <= a_last;
        end
    end

    logic [63:0] b_bt_data [64];
    logic        b_bt_last [64];
    int          b_bt_cyc  [64];
    int          b_nbt = 0;
    int          b_rd_cyc  [64];
    int          b_nrd = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (b_rd_en) begin
                b_rd_cyc[b_nrd] <= cyc;
                b_nrd <= b_nrd + 1;
            end
            if (b_valid && b_ready) begin
                b_bt_data[b_nbt] <= b_data;
                b_bt_last[b_nbt] <= b_last;
                b_bt_cyc[b_nbt]  <= cyc;
                b_nbt <= b_nbt + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [63:0] w);
        a_mem[a_wr] = w;
        a_wr++;
    endtask

    task automatic push_b(input logic [63:0] w);
        b_mem[b_wr] = w;
        b_wr++;
    endtask

    task automatic wait_a_beats(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (a_nbt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp1 [4];
        logic [63:0] w;
        logic [63:0] rw [100];
        int base_bt, base_rd, n_rd_r, gaps, derr, lerr, pushed, lastcnt;
        bit ok;

        rst_n = 1'b0; clr = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        exp1[0] = 16'hCDEF; exp1[1] = 16'h89AB; exp1[2] = 16'h4567; exp1[3] = 16'h0123;

        // Reset held with a non-empty FIFO.
        push_a(64'h0123_4567_89AB_CDEF);
        repeat (3) tick();
        @(negedge clk);
        check("rst_rd_en", a_rd_en, 0);
        check("rst_m_valid", a_valid, 0);
        check("rst_m_data", a_data, 0);
        check("rst_m_last", a_last, 0);

        // Release; single word streams out at full rate.
        @(posedge clk); #1;
        a_ready = 1'b1;
        rst_n   = 1'b1;
        @(negedge clk);
        check("post_rst_valid", a_valid, 0);
        check("post_rst_data", a_data, 0);
        check("post_rst_last", a_last, 0);
        repeat (10) tick();
        check("single_rd_count", a_nrd, 1);
        check("single_beats", a_nbt, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("single_data%0d", k), a_bt_data[k], exp1[k]);
            check($sformatf("single_cyc%0d", k), a_bt_cyc[k] - a_rd_cyc[0], 2 + k);
            check($sformatf("single_last%0d", k), a_bt_last[k], (k == 3) ? 1 : 0);
        end

        // Burst of 8 words with the sink always ready.
        base_bt = a_nbt; base_rd = a_nrd;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) w[16*k +: 16] = 16'(16'h1000 + 4*i + k);
            push_a(w);
        end
        repeat (45) tick();
        check("burst_rd_count", a_nrd - base_rd, 8);
        check("burst_beats", a_nbt - base_bt, 32);
        check("burst_latency", a_bt_cyc[base_bt] - a_rd_cyc[base_rd], 2);
        gaps = 0; derr = 0; lerr = 0;
        for (int j = 0; j < 32; j++) begin
            if (j > 0 && a_bt_cyc[base_bt+j] != a_bt_cyc[base_bt+j-1] + 1) gaps++;
            if (a_bt_data[base_bt+j] !== 16'(16'h1000 + j)) derr++;
            if (a_bt_last[base_bt+j] !== ((j % 4) == 3)) lerr++;
        end
        check("burst_gaps", gaps, 0);
        check("burst_data", derr, 0);
        check("burst_last", lerr, 0);

        // 100 random words, random backpressure, sporadic FIFO refill.
        base_bt = a_nbt; base_rd = a_nrd; pushed = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            a_ready = 1'($urandom_range(0, 1));
            if (pushed < 100 && $urandom_range(0, 2) == 0) begin
                w = {$urandom, $urandom};
                rw[pushed] = w;
                push_a(w);
                pushed++;
            end
            if (pushed == 100 && (a_nbt - base_bt) >= 400) break;
        end
        a_ready = 1'b1;
        repeat (3) tick();
        n_rd_r = a_nrd - base_rd;
        check("rand_rd_count", n_rd_r, 100);
        check("rand_beats", a_nbt - base_bt, 400);
        derr = 0; lerr = 0;
        for (int j = 0; j < 400; j++) begin
            w = rw[j/4];
            if (a_bt_data[base_bt+j] !== w[(j%4)*16 +: 16]) derr++;
            if (a_bt_last[base_bt+j] !== ((j % 4) == 3)) lerr++;
        end
        check("rand_data_order", derr, 0);
        check("rand_last", lerr, 0);
        check("rand_stall_stable", stab_viol, 0);
        check("rand_rd_while_empty", empty_viol, 0);
        check("rand_outstanding_le2", (max_out <= 2), 1);

        // RATIO=1: one word per clock.
        b_ready = 1'b1;
        for (int i = 0; i < 10; i++) push_b(64'hB000_0000_0000_0000 + 64'h1111 * i);
        repeat (20) tick();
        check("r1_rd_count", b_nrd, 10);
        check("r1_rd_span", b_rd_cyc[9] - b_rd_cyc[0], 9);
        check("r1_beats", b_nbt, 10);
        check("r1_beat_span", b_bt_cyc[9] - b_bt_cyc[0], 9);
        check("r1_latency", b_bt_cyc[0] - b_rd_cyc[0], 2);
        derr = 0; lastcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (b_bt_data[i] !== 64'hB000_0000_0000_0000 + 64'h1111 * i) derr++;
            if (b_bt_last[i] === 1'b1) lastcnt++;
        end
        check("r1_data", derr, 0);
        check("r1_last_all", lastcnt, 10);

        // Flush after two beats of a word, with the next read in flight.
        base_bt = a_nbt;
        push_a(64'hA004_A003_A002_A001);
        wait_a_beats(base_bt + 2, ok);
        check("clr_wait_beats", ok, 1);
        tick();
        a_ready = 1'b0;
        push_a(64'hB0B4_B0B3_B0B2_B0B1);
        @(negedge clk);
        check("clr_rd_issue", a_rd_en, 1);
        tick();
        clr = 1'b1;
        @(negedge clk);
        check("clr_rd_gated", a_rd_en, 0);
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("clr_valid_next", a_valid, 0);
        check("clr_data_next", a_data, 0);
        repeat (3) tick();
        check("clr_discarded", a_valid, 0);
        check("clr_beats_before", a_nbt - base_bt, 2);
        base_bt = a_nbt;
        a_ready = 1'b1;
        push_a(64'hC004_C003_C002_C001);
        wait_a_beats(base_bt + 4, ok);
        check("clr_fresh_wait", ok, 1);
        check("clr_fresh_beat0", a_bt_data[base_bt], 16'hC001);
        check("clr_fresh_last0", a_bt_last[base_bt], 0);
        check("clr_fresh_beat3", a_bt_data[base_bt+3], 16'hC004);
        check("clr_fresh_last3", a_bt_last[base_bt+3], 1);

        // Asynchronous reset in the middle of a word.
        base_bt = a_nbt;
        push_a(64'hE004_E003_E002_E001);
        wait_a_beats(base_bt + 2, ok);
        check("arst_wait_beats", ok, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", a_valid, 0);
        check("arst_data", a_data, 0);
        check("arst_last", a_last, 0);
        check("arst_rd_en", a_rd_en, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        base_bt = a_nbt;
        push_a(64'hF004_F003_F002_F001);
        wait_a_beats(base_bt + 4, ok);
        check("arst_fresh_wait", ok, 1);
        check("arst_fresh_beat0", a_bt_data[base_bt], 16'hF001);
        check("arst_fresh_beat3", a_bt_data[base_bt+3], 16'hF004);
        check("arst_fresh_last3", a_bt_last[base_bt+3], 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
